// File: rtl/tester_pkg.sv
// Shared types and constants for the exhaustive vector tester and its MISR.
package tester_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

  // Wide enough for any signature width; users slice the low SIG_W bits.
  localparam logic [63:0] SEED = '1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register: shifts with polynomial feedback and folds in din.
module misr_compactor
  import tester_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter int unsigned      N_OUT = 1,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic [N_OUT-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = SEED[SIG_W-1:0];
    end else if (en) begin
      sig_d = (sig_q << 1) ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED[SIG_W-1:0];
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/exhaustive_vector_tester.sv
// Sweeps every input vector PASSES times, holding each for HOLD cycles, and
// compacts the DUT response into a MISR signature checked against exp_sig.
module exhaustive_vector_tester
  import tester_pkg::*;
#(
  parameter int unsigned      N_IN   = 3,
  parameter int unsigned      N_OUT  = 1,
  parameter int unsigned      HOLD   = 20,
  parameter int unsigned      PASSES = 2,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  vec_out,
  output logic             vec_valid,
  output logic             busy,
  output logic             sample_valid,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned HCW = clog2(HOLD + 1);
  localparam int unsigned PCW = clog2(PASSES + 1);
  localparam logic [HCW-1:0]  HoldLast = HCW'(HOLD - 1);
  localparam logic [PCW-1:0]  PassLast = PCW'(PASSES - 1);
  localparam logic [N_IN-1:0] VecLast  = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [PCW-1:0]  pidx_q, pidx_d;
  logic            busy_q, busy_d;
  logic            vec_valid_q, vec_valid_d;
  logic            sample_valid_q, sample_valid_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            misr_init, misr_en;
  logic [SIG_W-1:0] sig_next;

  // pass must be valid alongside done, so the final capture is predicted here.
  always_comb begin
    sig_next = (signature << 1) ^ (signature[SIG_W-1] ? POLY : '0) ^ SIG_W'(dut_out);
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    pidx_d    = pidx_q;
    pass_d    = pass_q;
    misr_init = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRIVE;
          vec_d     = '0;
          hold_d    = '0;
          pidx_d    = '0;
          pass_d    = 1'b0;
          misr_init = 1'b1;
        end
      end
      DRIVE: begin
        if (hold_q == HoldLast) begin
          misr_en = 1'b1;
          hold_d  = '0;
          if (vec_q != VecLast) begin
            vec_d = vec_q + 1'b1;
          end else if (pidx_q != PassLast) begin
            pidx_d = pidx_q + 1'b1;
            vec_d  = '0;
          end else begin
            state_d = DONE;
            pass_d  = (sig_next == exp_sig);
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort freezes counters, signature and pass; only the state is forced.
    if (abort) begin
      state_d   = IDLE;
      vec_d     = vec_q;
      hold_d    = hold_q;
      pidx_d    = pidx_q;
      pass_d    = pass_q;
      misr_init = 1'b0;
      misr_en   = 1'b0;
    end

    busy_d         = (state_d != IDLE);
    vec_valid_d    = (state_d == DRIVE);
    sample_valid_d = (state_d == DRIVE) && (hold_d == HoldLast);
    done_d         = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      vec_q          <= '0;
      hold_q         <= '0;
      pidx_q         <= '0;
      busy_q         <= 1'b0;
      vec_valid_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      hold_q         <= hold_d;
      pidx_q         <= pidx_d;
      busy_q         <= busy_d;
      vec_valid_q    <= vec_valid_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
    end
  end

  misr_compactor #(
    .SIG_W (SIG_W),
    .N_OUT (N_OUT),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (misr_init),
    .en    (misr_en),
    .din   (dut_out),
    .sig   (signature)
  );

  assign vec_out      = vec_q;
  assign vec_valid    = vec_valid_q;
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign done         = done_q;
  assign pass         = pass_q;

endmodule
